// File: rtl/demux161_reg_pkg.sv
// Shared constants and types for the registered 1-to-16 demultiplexer.
// Holds default sizes, the all-ones completion mask and the fill-state encoding.
package demux161_reg_pkg;

  localparam int DEMUX_N  = 16;
  localparam int DEMUX_SW = 4;

  localparam logic [DEMUX_N-1:0] ALL_ONES = {DEMUX_N{1'b1}};

  typedef logic [DEMUX_SW-1:0] pos_t;

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_FILLING = 1'b1
  } fill_state_t;

  // A word is complete once every position has been flagged as written.
  function automatic logic isComplete(input logic [DEMUX_N-1:0] flags);
    return (flags == ALL_ONES);
  endfunction

endpackage

// File: rtl/demux161_reg_dec416.sv
// Combinational 4-to-16 one-hot decoder with enable.
// Structural inverse of the 16:1 select tree feeding this demux.
module dec416
  import demux161_reg_pkg::*;
#(
  parameter int SW = DEMUX_SW,
  parameter int N  = DEMUX_N
) (
  input  logic [SW-1:0] s,
  input  logic          e,
  output logic [N-1:0]  y
);

  always_comb begin
    y = '0;
    if (e) begin
      y[s] = 1'b1;
    end
  end

endmodule

// File: rtl/demux161_reg.sv
// Registered 1-to-16 demultiplexer that rebuilds a word from serially delivered bits
// and publishes it with a one-cycle valid pulse once every position has been written.
module demux161_reg
  import demux161_reg_pkg::*;
#(
  parameter int N  = DEMUX_N,
  parameter int SW = DEMUX_SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d,
  input  logic [SW-1:0] s,
  input  logic          we,
  input  logic          a,
  input  logic          clr,
  output logic [N-1:0]  x,
  output logic [N-1:0]  q,
  output logic          v,
  output logic [SW-1:0] p,
  output logic [N-1:0]  f
);

  logic [N-1:0]  r_x;
  logic [N-1:0]  r_q;
  logic          r_v;
  logic [SW-1:0] r_p;
  logic [N-1:0]  r_f;

  logic          w_en;
  logic [SW-1:0] w_t;
  logic [N-1:0]  w_hot;
  logic [N-1:0]  w_fOr;
  logic [N-1:0]  w_xWritten;
  logic          w_complete;

  fill_state_t   w_state;
  fill_state_t   w_stateNext;

  logic [N-1:0]  w_xNext;
  logic [N-1:0]  w_qNext;
  logic          w_vNext;
  logic [SW-1:0] w_pNext;
  logic [N-1:0]  w_fNext;

  // clr beats a simultaneous write, so it also gates the decoder.
  assign w_en = we & ~clr;
  assign w_t  = a ? r_p : s;

  dec416 #(
    .SW (SW),
    .N  (N)
  ) u_dec416 (
    .s (w_t),
    .e (w_en),
    .y (w_hot)
  );

  assign w_fOr      = r_f | w_hot;
  assign w_xWritten = (r_x & ~w_hot) | (w_hot & {N{d}});
  assign w_complete = w_en & isComplete(w_fOr);

  // Fill state is a view of the flags rather than a separate register.
  assign w_state = (r_f == '0) ? ST_EMPTY : ST_FILLING;

  always_comb begin
    w_stateNext = w_state;
    w_xNext     = r_x;
    w_qNext     = r_q;
    w_vNext     = 1'b0;
    w_pNext     = r_p;

    if (clr) begin
      w_stateNext = ST_EMPTY;
      w_pNext     = '0;
    end else if (we) begin
      w_xNext = w_xWritten;
      if (a) begin
        w_pNext = r_p + 1'b1;
      end
      if (w_complete) begin
        w_stateNext = ST_EMPTY;
        w_qNext     = w_xWritten;
        w_vNext     = 1'b1;
        w_pNext     = '0;
      end else begin
        w_stateNext = ST_FILLING;
      end
    end

    w_fNext = (w_stateNext == ST_EMPTY) ? '0 : w_fOr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_q <= '0;
      r_v <= 1'b0;
      r_p <= '0;
      r_f <= '0;
    end else begin
      r_x <= w_xNext;
      r_q <= w_qNext;
      r_v <= w_vNext;
      r_p <= w_pNext;
      r_f <= w_fNext;
    end
  end

  assign x = r_x;
  assign q = r_q;
  assign v = r_v;
  assign p = r_p;
  assign f = r_f;

endmodule

// File: tb/tb_demux161_reg.sv
// Directed self-checking bench for demux161_reg.
// Expected values are hand-computed from the word-assembly behaviour.
module tb_demux161_reg;

  logic        clk;
  logic        rst;
  logic        d;
  logic [3:0]  s;
  logic        we;
  logic        a;
  logic        clr;
  logic [15:0] x;
  logic [15:0] q;
  logic        v;
  logic [3:0]  p;
  logic [15:0] f;

  int checks = 0;
  int errors = 0;

  demux161_reg dut (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .s   (s),
    .we  (we),
    .a   (a),
    .clr (clr),
    .x   (x),
    .q   (q),
    .v   (v),
    .p   (p),
    .f   (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then sample 1ns after the following rising edge.
  task automatic applyStimulus(input logic iRst, input logic iWe, input logic iA,
                               input logic [3:0] iS, input logic iD, input logic iClr);
    @(negedge clk);
    rst = iRst;
    we  = iWe;
    a   = iA;
    s   = iS;
    d   = iD;
    clr = iClr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  logic [15:0] word;
  int          pulses;
  int          firstPulse;
  int          secondPulse;

  initial begin
    rst = 1'b1; we = 1'b0; a = 1'b0; s = 4'd0; d = 1'b0; clr = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("reset_x", 32'(x), 32'h0);
    checkOutput("reset_q", 32'(q), 32'h0);
    checkOutput("reset_f", 32'(f), 32'h0);
    checkOutput("reset_p", 32'(p), 32'h0);
    checkOutput("reset_v", 32'(v), 32'h0);

    // Auto fill with 0xA5C3, LSB first.
    word = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, word[i], 1'b0);
      if (i == 7) begin
        checkOutput("auto_mid_f", 32'(f), 32'h00FF);
        checkOutput("auto_mid_p", 32'(p), 32'd8);
        checkOutput("auto_mid_x", 32'(x), 32'h00C3);
      end
      if (i < 15) checkOutput("auto_no_v", 32'(v), 32'h0);
    end
    checkOutput("auto_v", 32'(v), 32'h1);
    checkOutput("auto_q", 32'(q), 32'hA5C3);
    checkOutput("auto_p", 32'(p), 32'h0);
    checkOutput("auto_f", 32'(f), 32'h0);
    checkOutput("auto_x", 32'(x), 32'hA5C3);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    checkOutput("idle_v", 32'(v), 32'h0);
    checkOutput("idle_q", 32'(q), 32'hA5C3);
    checkOutput("idle_x", 32'(x), 32'hA5C3);

    // Explicit scatter of 0x1234, descending, with overwrites of position 3.
    word = 16'h1234;
    for (int k = 15; k >= 4; k--) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'(k), word[k], 1'b0);
    end
    checkOutput("scatter_f_hi", 32'(f), 32'hFFF0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
    checkOutput("ovw_f_first", 32'(f), 32'hFFF8);
    checkOutput("ovw_x3_zero", 32'(x[3]), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
    checkOutput("ovw_f_same", 32'(f), 32'hFFF8);
    checkOutput("ovw_x3_one", 32'(x[3]), 32'h1);
    checkOutput("ovw_no_v", 32'(v), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
    for (int k = 2; k >= 0; k--) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'(k), word[k], 1'b0);
      if (k > 0) checkOutput("scatter_no_v", 32'(v), 32'h0);
    end
    checkOutput("scatter_v", 32'(v), 32'h1);
    checkOutput("scatter_q", 32'(q), 32'h1234);
    checkOutput("scatter_p", 32'(p), 32'h0);
    checkOutput("scatter_f", 32'(f), 32'h0);

    // 32 back-to-back auto writes: 0xBEEF then 0x0F0F.
    pulses = 0; firstPulse = -1; secondPulse = -1;
    for (int i = 0; i < 32; i++) begin
      word = (i < 16) ? 16'hBEEF : 16'h0F0F;
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, word[i % 16], 1'b0);
      if (v) begin
        pulses++;
        if (firstPulse < 0) firstPulse = i; else secondPulse = i;
      end
      if (i == 14) checkOutput("wrap_p15", 32'(p), 32'd15);
      if (i == 15) begin
        checkOutput("wrap_q1", 32'(q), 32'hBEEF);
        checkOutput("wrap_p0", 32'(p), 32'h0);
      end
      if (i == 16) begin
        checkOutput("b2b_f", 32'(f), 32'h0001);
        checkOutput("b2b_p", 32'(p), 32'h1);
        checkOutput("b2b_v_low", 32'(v), 32'h0);
      end
    end
    checkOutput("wrap_pulses", 32'(pulses), 32'd2);
    checkOutput("wrap_spacing", 32'(secondPulse - firstPulse), 32'd16);
    checkOutput("wrap_q2", 32'(q), 32'h0F0F);

    // Abort after 9 auto writes of 0x155; clr wins over a simultaneous write.
    word = 16'h0155;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, word[i], 1'b0);
    end
    checkOutput("abort_pre_f", 32'(f), 32'h01FF);
    checkOutput("abort_pre_p", 32'(p), 32'd9);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
    checkOutput("abort_f", 32'(f), 32'h0);
    checkOutput("abort_p", 32'(p), 32'h0);
    checkOutput("abort_v", 32'(v), 32'h0);
    checkOutput("abort_x", 32'(x), 32'h0F55);
    checkOutput("abort_q", 32'(q), 32'h0F0F);
    word = 16'h3C3C;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, word[i], 1'b0);
      if (i == 14) checkOutput("abort_refill_no_v", 32'(v), 32'h0);
    end
    checkOutput("abort_refill_v", 32'(v), 32'h1);
    checkOutput("abort_refill_q", 32'(q), 32'h3C3C);

    // Reset mid-word alongside a write.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
    end
    checkOutput("rstmid_pre_f", 32'(f), 32'h03FF);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
    checkOutput("rstmid_x", 32'(x), 32'h0);
    checkOutput("rstmid_q", 32'(q), 32'h0);
    checkOutput("rstmid_f", 32'(f), 32'h0);
    checkOutput("rstmid_p", 32'(p), 32'h0);
    checkOutput("rstmid_v", 32'(v), 32'h0);

    // Partial completion: flags 0xFFFE, overwrite s=5, then finish with s=0.
    for (int k = 1; k < 16; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'(k), 1'b1, 1'b0);
    end
    checkOutput("partial_f", 32'(f), 32'hFFFE);
    checkOutput("partial_no_v", 32'(v), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0);
    checkOutput("partial_ovw_v", 32'(v), 32'h0);
    checkOutput("partial_ovw_f", 32'(f), 32'hFFFE);
    checkOutput("partial_ovw_x", 32'(x), 32'hFFDE);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("partial_v", 32'(v), 32'h1);
    checkOutput("partial_q", 32'(q), 32'hFFDF);
    checkOutput("partial_f_clr", 32'(f), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("partial_v_drop", 32'(v), 32'h0);
    checkOutput("partial_q_hold", 32'(q), 32'hFFDF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
